// File: rtl/player_move_ctrl.sv
// Player sprite sequencer: erases, moves and redraws a SIZE x SIZE square on each movement tick.
// Optional build macro PLAYER_WRAP_EN: when defined, positions wrap at the screen bounds instead of clamping.
module player_move_ctrl #(
  parameter int         TICK_DIV  = 1000000,
  parameter int         SIZE      = 4,
  parameter int         X_MAX     = 159,
  parameter int         Y_MAX     = 119,
  parameter int         X_INIT    = 76,
  parameter int         Y_INIT    = 56,
  parameter logic [2:0] FG_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [9:0] SW,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic [7:0] playerx,
  output logic [6:0] playery,
  output logic       busy
);

  localparam int          CW        = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [7:0]  X_LIM     = 8'(X_MAX - SIZE + 1);
  localparam logic [6:0]  Y_LIM     = 7'(Y_MAX - SIZE + 1);
  localparam logic [2:0]  OFF_LAST  = 3'(SIZE - 1);

`ifdef PLAYER_WRAP_EN
  localparam logic [7:0] X_PAST_HI = 8'd0;
  localparam logic [7:0] X_PAST_LO = X_LIM;
  localparam logic [6:0] Y_PAST_HI = 7'd0;
  localparam logic [6:0] Y_PAST_LO = Y_LIM;
`else
  localparam logic [7:0] X_PAST_HI = X_LIM;
  localparam logic [7:0] X_PAST_LO = 8'd0;
  localparam logic [6:0] Y_PAST_HI = Y_LIM;
  localparam logic [6:0] Y_PAST_LO = 7'd0;
`endif

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    ERASE,
    UPDATE,
    DRAW
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic          pending;
  logic          clear_pending;
  logic          latch_dir;
  logic          apply_move;
  logic          step_right, step_left, step_down, step_up;
  logic          want_right, want_left, want_down, want_up, want_move;
  logic [2:0]    ox, oy, ox_n, oy_n;
  logic          scan_last;
  logic          plot_n;
  logic [2:0]    colour_n;
  logic [7:0]    base_x, new_x, x_n;
  logic [6:0]    base_y, new_y, y_n;
  logic          unused_sw;

  assign unused_sw  = ^SW[5:0];
  assign tick       = (tick_cnt == TICK_LAST);
  assign want_right = SW[9] & ~SW[8];
  assign want_left  = SW[8] & ~SW[9];
  assign want_down  = SW[7] & ~SW[6];
  assign want_up    = SW[6] & ~SW[7];
  assign want_move  = want_right | want_left | want_down | want_up;
  assign scan_last  = (ox == OFF_LAST) && (oy == OFF_LAST);
  assign busy       = (state != IDLE);

  // Bounded step using the direction latched when the move was accepted
  always_comb begin
    new_x = playerx;
    if (step_right) begin
      if (playerx >= X_LIM) new_x = X_PAST_HI;
      else                  new_x = playerx + 8'd1;
    end else if (step_left) begin
      if (playerx == 8'd0)  new_x = X_PAST_LO;
      else                  new_x = playerx - 8'd1;
    end

    new_y = playery;
    if (step_down) begin
      if (playery >= Y_LIM) new_y = Y_PAST_HI;
      else                  new_y = playery + 7'd1;
    end else if (step_up) begin
      if (playery == 7'd0)  new_y = Y_PAST_LO;
      else                  new_y = playery - 7'd1;
    end
  end

  // Next state plus the pixel to present on the registered VGA bus next cycle
  always_comb begin
    state_n       = state;
    ox_n          = ox;
    oy_n          = oy;
    plot_n        = 1'b0;
    colour_n      = 3'b000;
    base_x        = playerx;
    base_y        = playery;
    clear_pending = 1'b0;
    latch_dir     = 1'b0;
    apply_move    = 1'b0;

    case (state)
      INIT: begin
        // Nothing is on the bus yet in the first INIT cycle, so that cycle loads pixel 0
        if (!vga_plot) begin
          plot_n   = 1'b1;
          colour_n = FG_COLOUR;
          ox_n     = 3'd0;
          oy_n     = 3'd0;
        end else if (scan_last) begin
          state_n = IDLE;
        end else begin
          plot_n   = 1'b1;
          colour_n = FG_COLOUR;
          if (ox == OFF_LAST) begin
            ox_n = 3'd0;
            oy_n = oy + 3'd1;
          end else begin
            ox_n = ox + 3'd1;
          end
        end
      end

      IDLE: begin
        if (pending) begin
          clear_pending = 1'b1;
          if (want_move) begin
            latch_dir = 1'b1;
            state_n   = ERASE;
            plot_n    = 1'b1;
            colour_n  = BG_COLOUR;
            ox_n      = 3'd0;
            oy_n      = 3'd0;
          end
        end
      end

      ERASE: begin
        if (scan_last) begin
          state_n = UPDATE;
        end else begin
          plot_n   = 1'b1;
          colour_n = BG_COLOUR;
          if (ox == OFF_LAST) begin
            ox_n = 3'd0;
            oy_n = oy + 3'd1;
          end else begin
            ox_n = ox + 3'd1;
          end
        end
      end

      UPDATE: begin
        // The first DRAW pixel must already use the position being written this cycle
        apply_move = 1'b1;
        state_n    = DRAW;
        plot_n     = 1'b1;
        colour_n   = FG_COLOUR;
        ox_n       = 3'd0;
        oy_n       = 3'd0;
        base_x     = new_x;
        base_y     = new_y;
      end

      DRAW: begin
        if (scan_last) begin
          state_n = IDLE;
        end else begin
          plot_n   = 1'b1;
          colour_n = FG_COLOUR;
          if (ox == OFF_LAST) begin
            ox_n = 3'd0;
            oy_n = oy + 3'd1;
          end else begin
            ox_n = ox + 3'd1;
          end
        end
      end

      default: state_n = INIT;
    endcase

    x_n = plot_n ? (base_x + {5'd0, ox_n}) : 8'd0;
    y_n = plot_n ? (base_y + {4'd0, oy_n}) : 7'd0;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= INIT;
      tick_cnt   <= '0;
      pending    <= 1'b0;
      step_right <= 1'b0;
      step_left  <= 1'b0;
      step_down  <= 1'b0;
      step_up    <= 1'b0;
      ox         <= 3'd0;
      oy         <= 3'd0;
      playerx    <= 8'(X_INIT);
      playery    <= 7'(Y_INIT);
      vga_x      <= 8'd0;
      vga_y      <= 7'd0;
      vga_colour <= 3'b000;
      vga_plot   <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
      // A tick in the decision cycle is a fresh request and survives the clear
      pending  <= tick | (pending & ~clear_pending);
      if (latch_dir) begin
        step_right <= want_right;
        step_left  <= want_left;
        step_down  <= want_down;
        step_up    <= want_up;
      end
      if (apply_move) begin
        playerx <= new_x;
        playery <= new_y;
      end
      ox         <= ox_n;
      oy         <= oy_n;
      vga_x      <= x_n;
      vga_y      <= y_n;
      vga_colour <= colour_n;
      vga_plot   <= plot_n;
    end
  end

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed self-checking bench for player_move_ctrl: two instances (default position, right-edge position).
// Expected pixels, positions and cycle counts are hand-derived from the timing rules.
module tb_player_move_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] swA, swB;
  logic       sel;

  logic [7:0] aX, bX, aPx, bPx;
  logic [6:0] aY, bY, aPy, bPy;
  logic [2:0] aCol, bCol;
  logic       aPlot, bPlot, aBusy, bBusy;

  logic [7:0] oX, oPx;
  logic [6:0] oY, oPy;
  logic [2:0] oCol;
  logic       oPlot, oBusy;

  int checks = 0;
  int failures = 0;
  int cyc;

  logic [31:0] capVal [0:63];
  int capN, capStart, capFirst, capEnd;
  logic capOk;

  always #5 clock = ~clock;

  player_move_ctrl #(.TICK_DIV(4)) dutA (
    .CLOCK_50(clock), .reset(reset), .SW(swA),
    .vga_x(aX), .vga_y(aY), .vga_colour(aCol), .vga_plot(aPlot),
    .playerx(aPx), .playery(aPy), .busy(aBusy)
  );

  player_move_ctrl #(.TICK_DIV(2), .X_INIT(156)) dutB (
    .CLOCK_50(clock), .reset(reset), .SW(swB),
    .vga_x(bX), .vga_y(bY), .vga_colour(bCol), .vga_plot(bPlot),
    .playerx(bPx), .playery(bPy), .busy(bBusy)
  );

  assign oX    = sel ? bX : aX;
  assign oY    = sel ? bY : aY;
  assign oCol  = sel ? bCol : aCol;
  assign oPlot = sel ? bPlot : aPlot;
  assign oPx   = sel ? bPx : aPx;
  assign oPy   = sel ? bPy : aPy;
  assign oBusy = sel ? bBusy : aBusy;

  // Cycles since reset release; at the negedge of cycle n it reads n
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] sw);
    if (sel) swB = sw;
    else     swA = sw;
  endtask

  function automatic logic [31:0] pix(input int px, input int x, input int y, input int c);
    logic [7:0] p8, x8;
    logic [6:0] y7;
    logic [2:0] c3;
    p8 = 8'(px); x8 = 8'(x); y7 = 7'(y); c3 = 3'(c);
    return {6'd0, p8, x8, y7, c3};
  endfunction

  // Records one busy period of the selected instance; optionally changes SW after plot index flipAt
  task automatic captureMove(input int flipAt, input logic [9:0] flipSw);
    int budget;
    capN = 0; capOk = 1'b1; capStart = -1; capFirst = -1; capEnd = -1;
    budget = 0;
    while (!oBusy && budget < 200) begin
      @(negedge clock);
      budget++;
    end
    if (!oBusy) begin
      capOk = 1'b0;
      return;
    end
    capStart = cyc;
    while (oBusy && budget < 400) begin
      if (oPlot) begin
        if (capN < 64) capVal[capN] = {6'd0, oPx, oX, oY, oCol};
        if (capFirst < 0) capFirst = cyc;
        if (capN == flipAt) applyStimulus(flipSw);
        capN++;
      end
      @(negedge clock);
      budget++;
    end
    if (oBusy) capOk = 1'b0;
    else       capEnd = cyc;
  endtask

  task automatic checkScan(input string tag, input int base, input int px, input int x0, input int y0, input int c);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("%s[%0d]", tag, i), capVal[base + i], pix(px, x0 + i % 4, y0 + i / 4, c));
  endtask

  task automatic checkLatency(input string tag, input int div);
    checkOutput({tag, "_tick_phase"}, 32'(capFirst % div), 32'd1);
    checkOutput({tag, "_latency"}, 32'(capEnd - capFirst + 2), 32'd35);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nPlots, nBusy, prevEnd, hitDraw7;
    logic [7:0] nx, nx2;
    reset = 1'b1; swA = 10'd0; swB = 10'd0; sel = 1'b0;
    repeat (3) @(negedge clock);

    checkOutput("rst_plot", 32'(oPlot), 32'd0);
    checkOutput("rst_x", 32'(oX), 32'd0);
    checkOutput("rst_y", 32'(oY), 32'd0);
    checkOutput("rst_colour", 32'(oCol), 32'd0);
    checkOutput("rst_playerx", 32'(oPx), 32'd76);
    checkOutput("rst_playery", 32'(oPy), 32'd56);
    checkOutput("rst_busy", 32'(oBusy), 32'd1);

    // Initial draw after release
    reset = 1'b0;
    captureMove(-1, 10'd0);
    checkOutput("init_done", 32'(capOk), 32'd1);
    checkOutput("init_plots", 32'(capN), 32'd16);
    checkOutput("init_first", 32'(capFirst), 32'd1);
    checkOutput("init_idle_cyc", 32'(capEnd), 32'd17);
    checkScan("init_px", 0, 76, 76, 56, 7);

    // Right move; switches released mid-erase must not change the drawn position
    repeat (2) @(negedge clock);
    applyStimulus(10'b10_0000_0000);
    captureMove(5, 10'd0);
    checkOutput("right_done", 32'(capOk), 32'd1);
    checkOutput("right_plots", 32'(capN), 32'd32);
    checkScan("right_erase", 0, 76, 76, 56, 0);
    checkScan("right_draw", 16, 77, 77, 56, 7);
    checkLatency("right", 4);
    checkOutput("right_playerx", 32'(oPx), 32'd77);

    // Opposing switches cancel: no activity over several ticks
    applyStimulus(10'b11_0010_1101);
    nPlots = 0; nBusy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (oPlot) nPlots++;
      if (oBusy) nBusy++;
    end
    checkOutput("cancel_plots", 32'(nPlots), 32'd0);
    checkOutput("cancel_busy", 32'(nBusy), 32'd0);
    checkOutput("cancel_playerx", 32'(oPx), 32'd77);
    checkOutput("cancel_playery", 32'(oPy), 32'd56);

    // Diagonal right+down
    applyStimulus(10'b10_1000_0000);
    captureMove(20, 10'd0);
    checkOutput("diag_plots", 32'(capN), 32'd32);
    checkScan("diag_erase", 0, 77, 77, 56, 0);
    checkScan("diag_draw", 16, 78, 78, 57, 7);
    checkLatency("diag", 4);
    checkOutput("diag_playery", 32'(oPy), 32'd57);

    // Instance B at the right bound with TICK_DIV=2
    sel = 1'b1;
`ifdef PLAYER_WRAP_EN
    nx = 8'd0; nx2 = 8'd1;
`else
    nx = 8'd156; nx2 = 8'd156;
`endif
    applyStimulus(10'b10_0000_0000);
    captureMove(-1, 10'd0);
    checkOutput("edge1_plots", 32'(capN), 32'd32);
    checkScan("edge1_erase", 0, 156, 156, 56, 0);
    checkScan("edge1_draw", 16, nx, nx, 56, 7);
    checkLatency("edge1", 2);
    checkOutput("edge1_playerx", 32'(oPx), 32'(nx));
    prevEnd = capEnd;

    // Merged ticks start the next move straight away; switch to up during the last draw plot
    captureMove(31, 10'b00_0100_0000);
    checkOutput("edge2_plots", 32'(capN), 32'd32);
    checkOutput("edge2_gap", 32'(capStart - prevEnd), 32'd1);
    checkOutput("edge2_erase0", capVal[0], pix(nx, nx, 56, 0));
    checkOutput("edge2_draw15", capVal[31], pix(nx2, nx2 + 3, 59, 7));
    checkOutput("edge2_playerx", 32'(oPx), 32'(nx2));
    prevEnd = capEnd;

    for (int k = 0; k < 3; k++) begin
      captureMove((k == 2) ? 31 : -1, 10'd0);
      checkOutput($sformatf("up%0d_plots", k), 32'(capN), 32'd32);
      checkOutput($sformatf("up%0d_gap", k), 32'(capStart - prevEnd), 32'd1);
      checkOutput($sformatf("up%0d_span", k), 32'(capEnd - capFirst), 32'd33);
      checkOutput($sformatf("up%0d_draw0", k), capVal[16], pix(nx2, nx2, 55 - k, 7));
      checkOutput($sformatf("up%0d_playery", k), 32'(oPy), 32'(55 - k));
      prevEnd = capEnd;
    end

    // Reset during DRAW plot 7 of instance A
    sel = 1'b0;
    repeat (2) @(negedge clock);
    applyStimulus(10'b10_0000_0000);
    nPlots = 0; hitDraw7 = 0;
    for (int i = 0; i < 120 && hitDraw7 == 0; i++) begin
      @(negedge clock);
      if (oPlot) begin
        nPlots++;
        if (nPlots == 24) begin
          checkOutput("abort_colour", 32'(oCol), 32'd7);
          reset = 1'b1;
          #1;
          checkOutput("abort_plot", 32'(oPlot), 32'd0);
          checkOutput("abort_busy", 32'(oBusy), 32'd1);
          checkOutput("abort_playerx", 32'(oPx), 32'd76);
          hitDraw7 = 1;
        end
      end
    end
    checkOutput("abort_reached", 32'(hitDraw7), 32'd1);
    @(negedge clock);
    applyStimulus(10'd0);
    reset = 1'b0;
    captureMove(-1, 10'd0);
    checkOutput("reinit_plots", 32'(capN), 32'd16);
    checkOutput("reinit_idle_cyc", 32'(capEnd), 32'd17);
    checkScan("reinit_px", 0, 76, 76, 56, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
